// File: rtl/prefetcher_pkg.sv
// Shared types for the prefetcher read-side responder: queued request entry,
// response FSM states and the page-aware latency select.
package prefetcher_pkg;

    localparam int unsigned RSP_ADDR_W  = 16;
    localparam int unsigned RSP_LEN_W   = 8;
    localparam int unsigned RSP_TID_W   = 8;
    localparam int unsigned RSP_DELAY_W = 7;

    typedef struct packed {
        logic [RSP_ADDR_W-1:0] addr;
        logic [RSP_LEN_W-1:0]  len;
        logic [RSP_TID_W-1:0]  id;
    } rd_req_t;

    typedef struct packed {
        rd_req_t                req;
        logic [RSP_DELAY_W-1:0] countdown;
    } rd_entry_t;

    typedef enum logic {
        RSP_IDLE,
        RSP_BURST
    } rsp_state_t;

    function automatic logic [RSP_DELAY_W-1:0] select_delay(
        input logic                   page_hit,
        input logic [RSP_DELAY_W-1:0] short_delay,
        input logic [RSP_DELAY_W-1:0] long_delay
    );
        return page_hit ? short_delay : long_delay;
    endfunction

endpackage

// File: rtl/rd_req_fifo.sv
// In-order circular queue of outstanding read requests; every stored entry
// carries its own latency countdown so latencies overlap across requests.
module rd_req_fifo
    import prefetcher_pkg::*;
#(
    parameter int unsigned LOG_QUEUE_SIZE = 4
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   push,
    input  rd_req_t                push_req,
    input  logic [RSP_DELAY_W-1:0] push_delay,
    input  logic                   pop,
    output rd_req_t                head,
    output logic                   head_ready,
    output logic                   next_ready,
    output logic                   space_next
);

    localparam int unsigned DEPTH = 1 << LOG_QUEUE_SIZE;
    localparam int unsigned CNT_W = LOG_QUEUE_SIZE + 1;
    localparam logic [RSP_DELAY_W-1:0] DUE = RSP_DELAY_W'(1);

    rd_entry_t mem [DEPTH];

    logic [LOG_QUEUE_SIZE-1:0] head_ptr;
    logic [LOG_QUEUE_SIZE-1:0] tail_ptr;
    logic [LOG_QUEUE_SIZE-1:0] next_ptr;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          count_nxt;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    assign next_ptr   = head_ptr + LOG_QUEUE_SIZE'(1);
    assign head       = mem[head_ptr].req;
    assign space_next = (count_nxt < CNT_W'(DEPTH));

    // "Ready" means the countdown reaches zero at the coming edge, so the
    // responder can start the burst on exactly that edge.
    assign head_ready = (count != '0) && (mem[head_ptr].countdown <= DUE);
    assign next_ready = (count > CNT_W'(1)) && (mem[next_ptr].countdown <= DUE);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                tail_ptr <= tail_ptr + LOG_QUEUE_SIZE'(1);
            end
            if (pop) begin
                head_ptr <= next_ptr;
            end
        end
    end

    // Stale slots also count down; they are never observed because readiness
    // is gated by the occupancy count, and a push reloads the slot.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mem[i].countdown != '0) begin
                mem[i].countdown <= mem[i].countdown - DUE;
            end
        end
        if (push) begin
            mem[tail_ptr] <= '{req: push_req, countdown: push_delay};
        end
    end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read responder standing in for DRAM: in-order bursts after a page-aware
// latency, with each beat's data being its own address replicated over the bus.
module axi_rd_responder
    import prefetcher_pkg::*;
#(
    parameter int unsigned ADDR_BITS            = 16,
    parameter int unsigned TID_WIDTH            = 8,
    parameter int unsigned BURST_LEN_WIDTH      = 8,
    parameter int unsigned LOG_BLOCK_DATA_BYTES = 7,
    parameter int unsigned LOG_QUEUE_SIZE       = 4,
    parameter int unsigned PAGE_OFFSET_WIDTH    = 8,
    parameter int unsigned DELAY_WIDTH          = 7,
    parameter int unsigned SHORT_DELAY          = 80,
    parameter int unsigned LONG_DELAY           = 100
) (
    input  logic                                   clk,
    input  logic                                   resetN,
    input  logic                                   s_ar_valid,
    output logic                                   s_ar_ready,
    input  logic [ADDR_BITS-1:0]                   s_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0]             s_ar_len,
    input  logic [TID_WIDTH-1:0]                   s_ar_id,
    output logic                                   s_r_valid,
    input  logic                                   s_r_ready,
    output logic                                   s_r_last,
    output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]   s_r_data,
    output logic [TID_WIDTH-1:0]                   s_r_id,
    output logic [1:0]                             s_r_resp
);

    localparam int unsigned DATA_WIDTH = 8 << LOG_BLOCK_DATA_BYTES;
    localparam int unsigned ADDR_REPL  = DATA_WIDTH / ADDR_BITS;

    logic                       ar_ready;
    logic                       accept;
    logic [ADDR_BITS-1:0]       ar_page;
    logic [ADDR_BITS-1:0]       last_page;
    logic                       page_valid;
    rd_req_t                    push_req;
    logic [DELAY_WIDTH-1:0]     push_delay;

    rd_req_t                    head;
    logic                       head_ready;
    logic                       next_ready;
    logic                       space_next;
    logic                       pop;

    rsp_state_t                 state;
    rsp_state_t                 state_nxt;
    logic [BURST_LEN_WIDTH-1:0] beat;
    logic [BURST_LEN_WIDTH-1:0] beat_nxt;
    logic                       beat_last;
    logic [ADDR_BITS-1:0]       beat_addr;

    assign accept     = s_ar_valid && ar_ready;
    assign s_ar_ready = ar_ready;
    assign ar_page    = s_ar_addr >> PAGE_OFFSET_WIDTH;

    assign push_req   = '{addr: s_ar_addr, len: s_ar_len, id: s_ar_id};
    assign push_delay = select_delay(page_valid && (ar_page == last_page),
                                     DELAY_WIDTH'(SHORT_DELAY),
                                     DELAY_WIDTH'(LONG_DELAY));

    rd_req_fifo #(
        .LOG_QUEUE_SIZE (LOG_QUEUE_SIZE)
    ) u_fifo (
        .clk        (clk),
        .resetN     (resetN),
        .push       (accept),
        .push_req   (push_req),
        .push_delay (push_delay),
        .pop        (pop),
        .head       (head),
        .head_ready (head_ready),
        .next_ready (next_ready),
        .space_next (space_next)
    );

    // Ready reflects the occupancy after this edge, so a same-cycle pop
    // never lets an accept through into a full queue.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ar_ready   <= 1'b0;
            last_page  <= '0;
            page_valid <= 1'b0;
        end else begin
            ar_ready <= space_next;
            if (accept) begin
                last_page  <= ar_page;
                page_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= RSP_IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    assign beat_last = (beat == head.len);

    // On the final beat, chain straight into the next entry if its latency
    // has already run out, so consecutive bursts have no idle cycle.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        pop       = 1'b0;
        case (state)
            RSP_IDLE: begin
                if (head_ready) begin
                    state_nxt = RSP_BURST;
                    beat_nxt  = '0;
                end
            end
            RSP_BURST: begin
                if (s_r_ready) begin
                    if (beat_last) begin
                        pop      = 1'b1;
                        beat_nxt = '0;
                        if (!next_ready) begin
                            state_nxt = RSP_IDLE;
                        end
                    end else begin
                        beat_nxt = beat + BURST_LEN_WIDTH'(1);
                    end
                end
            end
        endcase
    end

    assign beat_addr = head.addr + (ADDR_BITS'(beat) << LOG_BLOCK_DATA_BYTES);

    assign s_r_valid = (state == RSP_BURST);
    assign s_r_last  = s_r_valid && beat_last;
    assign s_r_id    = s_r_valid ? head.id : '0;
    assign s_r_data  = s_r_valid ? {ADDR_REPL{beat_addr}} : '0;
    assign s_r_resp  = '0;

endmodule
